calc_sequencer: RTL and testbench

Command-driven sequencer for the RPN `calculator` block. It buffers a stream of ENTER/ADD/MULTIPLY/END tokens in a small FIFO and replays them to the calculator as correctly spaced single-cycle pulses. At each END it captures the result, overflow and error, then clears the calculator for the next program. It sits between a host-side command source and one `calculator` instance.

---
 rtl/calc_seq_pkg.sv | 31 +++
 rtl/calc_seq_if.sv | 13 +
 rtl/calc_seq_fifo.sv | 47 ++++
 rtl/calc_sequencer.sv | 166 ++++++++++++++++
 tb/tb_calc_sequencer.sv | 453 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_seq_pkg.sv
// Shared types and widths for the calculator command sequencer.
package calc_seq_pkg;

  localparam int DATA_W   = 8;
  localparam int RESULT_W = 16;
  localparam int ERROR_W  = 4;
  localparam int CMD_W    = 10;

  typedef enum logic [1:0] {
    OP_ENTER = 2'd0,
    OP_ADD   = 2'd1,
    OP_MUL   = 2'd2,
    OP_END   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FLUSH,
    S_REPORT,
    S_CLEAR
  } state_e;

  // One FIFO entry: opcode in the top two bits, operand below.
  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/calc_seq_if.sv
// Host command channel of the calculator sequencer (valid/ready push only).
interface calc_seq_if;
  import calc_seq_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);

endinterface

// File: rtl/calc_seq_fifo.sv
// Synchronous DEPTH x CMD_W command FIFO with extra-MSB wrap pointers.
module calc_seq_fifo
  import calc_seq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  cmd_t push_cmd,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  cmd_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_cmd;
  end

endmodule

// File: rtl/calc_sequencer.sv
// Replays buffered RPN commands to a calculator as spaced pulses and reports at END.
// Optional: define CALC_SEQ_OVERFLOW_STOP_EN to flush the program on a sampled overflow.
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int GAP       = 2,
  parameter int CLEAR_LEN = 10
) (
  input  logic                clock,
  input  logic                reset,
  calc_seq_if.slave           cmd,
  output logic                calc_enter,
  output logic                calc_add,
  output logic                calc_multiply,
  output logic [DATA_W-1:0]   calc_data,
  output logic                calc_clear,
  input  logic [RESULT_W-1:0] calc_result,
  input  logic                calc_overflow,
  input  logic [ERROR_W-1:0]  calc_error,
  output logic                busy,
  output logic                done,
  output logic [RESULT_W-1:0] final_result,
  output logic                final_overflow,
  output logic [ERROR_W-1:0]  final_error
);

  localparam int CNT_MAX = (GAP > CLEAR_LEN) ? GAP : CLEAR_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state;
  state_e             next_state;
  logic [CNT_W-1:0]   cnt;
  logic               wait_last;
  logic               clear_last;
  logic               halt;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  cmd_t               push_cmd;
  cmd_t               head;
  logic               ovf_seen;

  logic                enter_nxt;
  logic                add_nxt;
  logic                mul_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic                clear_nxt;
  logic                done_nxt;
  logic [RESULT_W-1:0] result_nxt;
  logic                overflow_nxt;
  logic [ERROR_W-1:0]  error_nxt;
  logic                ovf_seen_nxt;

  assign push          = cmd.cmd_valid && !full;
  assign push_cmd      = cmd_t'({cmd.cmd_op, cmd.cmd_data});
  assign cmd.cmd_ready = !full;
  assign busy          = (state != S_IDLE) || !empty;
  assign wait_last     = (cnt == CNT_W'(GAP - 1));
  assign clear_last    = (cnt == CNT_W'(CLEAR_LEN - 1));

`ifdef CALC_SEQ_OVERFLOW_STOP_EN
  assign halt = (calc_error != '0) || calc_overflow;
`else
  assign halt = (calc_error != '0);
`endif

  calc_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .push_cmd (push_cmd),
    .pop      (pop),
    .head     (head),
    .full     (full),
    .empty    (empty)
  );

  // cnt restarts on every state change, so it measures time spent in WAIT/CLEAR.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= (state != next_state) ? '0 : cnt + CNT_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = (head.op == OP_END) ? S_REPORT : S_ISSUE;
        end
      end
      S_ISSUE:  next_state = S_WAIT;
      S_WAIT: begin
        if (wait_last) next_state = halt ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (!empty) begin
          pop = 1'b1;
          if (head.op == OP_END) next_state = S_REPORT;
        end
      end
      S_REPORT: next_state = S_CLEAR;
      S_CLEAR: begin
        if (clear_last) next_state = S_IDLE;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs are registered: values computed here appear together with next_state.
  always_comb begin
    enter_nxt    = (next_state == S_ISSUE) && (head.op == OP_ENTER);
    add_nxt      = (next_state == S_ISSUE) && (head.op == OP_ADD);
    mul_nxt      = (next_state == S_ISSUE) && (head.op == OP_MUL);
    data_nxt     = pop ? head.data : calc_data;
    clear_nxt    = (next_state == S_CLEAR);
    done_nxt     = (state == S_REPORT);
    result_nxt   = final_result;
    overflow_nxt = final_overflow;
    error_nxt    = final_error;
    ovf_seen_nxt = ovf_seen;
    if (state == S_WAIT && wait_last) ovf_seen_nxt = ovf_seen | calc_overflow;
    if (state == S_REPORT) begin
      result_nxt   = calc_result;
      overflow_nxt = calc_overflow | ovf_seen;
      error_nxt    = calc_error;
      ovf_seen_nxt = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      calc_enter     <= 1'b0;
      calc_add       <= 1'b0;
      calc_multiply  <= 1'b0;
      calc_data      <= '0;
      calc_clear     <= 1'b0;
      done           <= 1'b0;
      final_result   <= '0;
      final_overflow <= 1'b0;
      final_error    <= '0;
      ovf_seen       <= 1'b0;
    end else begin
      calc_enter     <= enter_nxt;
      calc_add       <= add_nxt;
      calc_multiply  <= mul_nxt;
      calc_data      <= data_nxt;
      calc_clear     <= clear_nxt;
      done           <= done_nxt;
      final_result   <= result_nxt;
      final_overflow <= overflow_nxt;
      final_error    <= error_nxt;
      ovf_seen       <= ovf_seen_nxt;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer with a behavioural RPN calculator stand-in.
// Expectations honour CALC_SEQ_OVERFLOW_STOP_EN when it is defined for the build.
module tb_calc_sequencer;
  import calc_seq_pkg::*;

  localparam int DEPTH     = 8;
  localparam int GAP       = 2;
  localparam int CLEAR_LEN = 10;

  typedef struct { logic [1:0] op; logic [7:0] d; } tok_t;
  typedef struct { logic [1:0] op; logic [7:0] d; int c; } pulse_t;
  typedef struct { logic [15:0] r; logic o; logic [3:0] e; int c; } done_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  calc_seq_if host();
  logic        calc_enter, calc_add, calc_multiply, calc_clear;
  logic [7:0]  calc_data;
  logic [15:0] calc_result, final_result;
  logic        calc_overflow, final_overflow, busy, done;
  logic [3:0]  calc_error, final_error;

  calc_sequencer #(.DEPTH(DEPTH), .GAP(GAP), .CLEAR_LEN(CLEAR_LEN)) dut (
    .clock(clock), .reset(reset), .cmd(host),
    .calc_enter(calc_enter), .calc_add(calc_add), .calc_multiply(calc_multiply),
    .calc_data(calc_data), .calc_clear(calc_clear),
    .calc_result(calc_result), .calc_overflow(calc_overflow), .calc_error(calc_error),
    .busy(busy), .done(done),
    .final_result(final_result), .final_overflow(final_overflow), .final_error(final_error)
  );

  // Calculator stand-in: 16-deep stack, error 1 = underflow, 2 = stack full; error is sticky.
  logic [15:0] stk [32];
  logic [4:0]  sp;
  logic [31:0] alu_w;

  function automatic logic [31:0] alu(input logic [15:0] a, input logic [15:0] b, input logic mul);
    return mul ? ({16'h0, a} * {16'h0, b}) : ({16'h0, a} + {16'h0, b});
  endfunction

  assign alu_w = alu(stk[sp - 5'd1], stk[sp - 5'd2], calc_multiply);

  always @(posedge clock) begin
    if (reset || calc_clear) begin
      sp <= '0; calc_result <= '0; calc_overflow <= 1'b0; calc_error <= '0;
    end else if (calc_error == 4'h0) begin
      if (calc_enter) begin
        if (sp == 5'd16) calc_error <= 4'h2;
        else begin
          stk[sp] <= {8'h00, calc_data}; sp <= sp + 5'd1;
          calc_result <= {8'h00, calc_data}; calc_overflow <= 1'b0;
        end
      end else if (calc_add || calc_multiply) begin
        if (sp < 5'd2) calc_error <= 4'h1;
        else begin
          stk[sp - 5'd2] <= alu_w[15:0]; sp <= sp - 5'd1;
          calc_result <= alu_w[15:0]; calc_overflow <= |alu_w[31:16];
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  pulse_t pq[$];
  done_t  dq[$];
  int     cq[$];
  int     acc_cyc[$];
  tok_t   prog[$];
  tok_t   exp_q[$];
  logic [15:0] exp_res;
  logic        exp_ovf;
  logic [3:0]  exp_err;
  logic        saw_full;
  pulse_t      mp;
  done_t       md;

  always @(negedge clock) begin
    if (!reset) begin
      if (calc_enter || calc_add || calc_multiply) begin
        checks++;
        if ($countones({calc_enter, calc_add, calc_multiply}) != 1) begin
          errors++;
          $display("FAIL one_hot_pulse at cycle %0d: got %b, required exactly one bit", cyc,
                   {calc_enter, calc_add, calc_multiply});
        end
        mp.op = calc_add ? 2'd1 : (calc_multiply ? 2'd2 : 2'd0);
        mp.d  = calc_data;
        mp.c  = cyc;
        pq.push_back(mp);
      end
      if (done) begin
        md.r = final_result; md.o = final_overflow; md.e = final_error; md.c = cyc;
        dq.push_back(md);
      end
      if (calc_clear) cq.push_back(cyc);
    end
  end

  // Program-level reference: interpret the token list as an RPN program.
  function automatic void ref_run();
    longint st[$];
    longint a, b, w;
    bit stop, ov;
    exp_q.delete(); exp_ovf = 1'b0; exp_err = 4'h0; stop = 0;
    foreach (prog[i]) begin
      if (prog[i].op == 2'd3) break;
      if (stop) continue;
      exp_q.push_back(prog[i]);
      ov = 0;
      if (prog[i].op == 2'd0) begin
        if (st.size() >= 16) exp_err = 4'h2;
        else st.push_back(longint'(prog[i].d));
      end else if (st.size() < 2) begin
        exp_err = 4'h1;
      end else begin
        a = st.pop_back(); b = st.pop_back();
        w = (prog[i].op == 2'd1) ? a + b : a * b;
        if (w > 65535) begin ov = 1; exp_ovf = 1'b1; end
        st.push_back(w % 65536);
      end
      if (exp_err != 4'h0) stop = 1;
`ifdef CALC_SEQ_OVERFLOW_STOP_EN
      if (ov) stop = 1;
`endif
    end
    exp_res = (st.size() > 0) ? 16'(st[st.size() - 1]) : 16'h0;
  endfunction

  function automatic void add_tok(input logic [1:0] op, input logic [7:0] d);
    tok_t t;
    t.op = op; t.d = d;
    prog.push_back(t);
  endfunction

  task automatic clear_logs();
    pq.delete(); dq.delete(); cq.delete(); acc_cyc.delete(); prog.delete(); saw_full = 1'b0;
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clock);
    host.cmd_valid = 1'b1; host.cmd_op = op; host.cmd_data = d;
    while (!host.cmd_ready && n < 400) begin @(negedge clock); n++; end
    if (n > 0) saw_full = 1'b1;
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL push_timeout: cmd_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clock); #1;
    acc_cyc.push_back(cyc);
    host.cmd_valid = 1'b0;
  endtask

  task automatic send_prog(input int max_gap);
    foreach (prog[i]) begin
      push(prog[i].op, prog[i].d);
      repeat ($urandom_range(0, max_gap)) @(negedge clock);
    end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (dq.size() == 0 && n < budget) begin @(negedge clock); n++; end
    checks++;
    if (dq.size() == 0) begin
      errors++; $display("FAIL done_timeout: done count 0 after %0d cycles, required 1", n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin @(negedge clock); n++; end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks += 4;
    if ({calc_enter, calc_add, calc_multiply, calc_clear, calc_data} !== 12'h0) begin
      errors++; $display("FAIL reset_calc_outputs: got %h, required 0",
                         {calc_enter, calc_add, calc_multiply, calc_clear, calc_data});
    end
    if ({done, final_result, final_overflow, final_error} !== 22'h0) begin
      errors++; $display("FAIL reset_final_outputs: got %h, required 0",
                         {done, final_result, final_overflow, final_error});
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (host.cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b, required 1", host.cmd_ready);
    end
  endtask

  task automatic test_basic();
    clear_logs();
    add_tok(0, 8'h02); add_tok(0, 8'h03); add_tok(2, 0); add_tok(0, 8'h04);
    add_tok(0, 8'h05); add_tok(2, 0); add_tok(1, 0); add_tok(3, 0);
    ref_run();
    send_prog(0);
    wait_done(400);
    wait_idle(400);
    checks++;
    if (pq.size() != exp_q.size()) begin
      errors++; $display("FAIL basic_pulse_count: got %0d, required %0d", pq.size(), exp_q.size());
    end else begin
      foreach (pq[i]) begin
        checks++;
        if (pq[i].op !== exp_q[i].op || (exp_q[i].op == 2'd0 && pq[i].d !== exp_q[i].d)) begin
          errors++; $display("FAIL basic_pulse[%0d]: got op %0d data %h, required op %0d data %h",
                             i, pq[i].op, pq[i].d, exp_q[i].op, exp_q[i].d);
        end
        if (i > 0) begin
          checks++;
          if (pq[i].c - pq[i-1].c != GAP + 2) begin
            errors++; $display("FAIL basic_spacing[%0d]: got %0d cycles, required %0d",
                               i, pq[i].c - pq[i-1].c, GAP + 2);
          end
        end
      end
      checks++;
      if (pq[0].c != acc_cyc[0] + 1) begin
        errors++; $display("FAIL first_op_latency: pulse at cycle %0d, required %0d",
                           pq[0].c, acc_cyc[0] + 1);
      end
    end
    if (dq.size() > 0 && pq.size() > 0) begin
      checks += 5;
      if (dq.size() != 1) begin errors++; $display("FAIL basic_done_count: got %0d, required 1", dq.size()); end
      if (dq[0].r !== 16'h001a || dq[0].o !== 1'b0 || dq[0].e !== 4'h0) begin
        errors++; $display("FAIL basic_final: got %h/%b/%h, required 001a/0/0", dq[0].r, dq[0].o, dq[0].e);
      end
      if (dq[0].c != pq[pq.size() - 1].c + GAP + 3) begin
        errors++; $display("FAIL end_latency: done at cycle %0d, required %0d",
                           dq[0].c, pq[pq.size() - 1].c + GAP + 3);
      end
      if (cq.size() != CLEAR_LEN) begin
        errors++; $display("FAIL clear_length: got %0d cycles, required %0d", cq.size(), CLEAR_LEN);
      end
      if (cq.size() == 0 || cq[0] != dq[0].c) begin
        errors++; $display("FAIL clear_start: got cycle %0d, required %0d",
                           (cq.size() > 0) ? cq[0] : -1, dq[0].c);
      end
    end
  endtask

  task automatic test_empty_end();
    clear_logs();
    add_tok(3, 0);
    send_prog(0);
    wait_done(100);
    wait_idle(100);
    checks++;
    if (pq.size() != 0) begin errors++; $display("FAIL empty_end_pulses: got %0d, required 0", pq.size()); end
    if (dq.size() > 0) begin
      checks += 2;
      if (dq[0].r !== 16'h0 || dq[0].e !== 4'h0 || dq[0].o !== 1'b0) begin
        errors++; $display("FAIL empty_end_final: got %h/%b/%h, required 0000/0/0", dq[0].r, dq[0].o, dq[0].e);
      end
      if (dq[0].c != acc_cyc[0] + 2) begin
        errors++; $display("FAIL empty_end_latency: done at cycle %0d, required %0d", dq[0].c, acc_cyc[0] + 2);
      end
    end
  endtask

  task automatic test_overflow();
    int muls;
    clear_logs();
    add_tok(0, 8'hff); add_tok(0, 8'hff); add_tok(0, 8'hff);
    add_tok(2, 0); add_tok(2, 0); add_tok(3, 0);
    ref_run();
    send_prog(1);
    wait_done(400);
    wait_idle(400);
    muls = 0;
    foreach (pq[i]) if (pq[i].op == 2'd2) muls++;
    checks += 2;
    if (pq.size() != exp_q.size()) begin
      errors++; $display("FAIL ovf_pulse_count: got %0d, required %0d", pq.size(), exp_q.size());
    end
    if (muls != 2) begin errors++; $display("FAIL ovf_mul_count: got %0d, required 2", muls); end
    if (dq.size() > 0) begin
      checks += 3;
      if (dq.size() != 1) begin errors++; $display("FAIL ovf_done_count: got %0d, required 1", dq.size()); end
      if (dq[0].o !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, required 1", dq[0].o); end
      if (dq[0].r !== exp_res || dq[0].e !== exp_err) begin
        errors++; $display("FAIL ovf_final: got %h/%h, required %h/%h", dq[0].r, dq[0].e, exp_res, exp_err);
      end
    end
  endtask

  task automatic test_error_flush();
    clear_logs();
    add_tok(0, 8'h05); add_tok(1, 0); add_tok(0, 8'h07); add_tok(2, 0); add_tok(3, 0);
    ref_run();
    send_prog(0);
    wait_done(400);
    wait_idle(400);
    checks++;
    if (pq.size() != 2) begin
      errors++; $display("FAIL err_pulse_count: got %0d, required 2", pq.size());
    end else begin
      checks++;
      if (pq[0].op !== 2'd0 || pq[0].d !== 8'h05 || pq[1].op !== 2'd1) begin
        errors++; $display("FAIL err_pulses: got %0d/%h,%0d, required 0/05,1", pq[0].op, pq[0].d, pq[1].op);
      end
    end
    if (dq.size() > 0) begin
      checks += 2;
      if (dq[0].e === 4'h0) begin errors++; $display("FAIL err_nonzero: got %h, required nonzero", dq[0].e); end
      if (dq[0].e !== exp_err || dq.size() != 1) begin
        errors++; $display("FAIL err_final: got %h (done %0d), required %h (done 1)", dq[0].e, dq.size(), exp_err);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    for (int i = 1; i <= DEPTH + 4; i++) add_tok(0, 8'(i));
    add_tok(3, 0);
    send_prog(0);
    wait_done(600);
    wait_idle(400);
    checks += 2;
    if (saw_full !== 1'b1) begin errors++; $display("FAIL bp_ready_low: got %b, required 1", saw_full); end
    if (pq.size() != DEPTH + 4) begin
      errors++; $display("FAIL bp_count: got %0d, required %0d", pq.size(), DEPTH + 4);
    end else begin
      foreach (pq[i]) begin
        checks++;
        if (pq[i].d !== 8'(i + 1)) begin
          errors++; $display("FAIL bp_data[%0d]: got %h, required %h", i, pq[i].d, 8'(i + 1));
        end
      end
    end
    if (dq.size() > 0) begin
      checks++;
      if (dq[0].r !== 16'(DEPTH + 4)) begin
        errors++; $display("FAIL bp_final: got %h, required %h", dq[0].r, 16'(DEPTH + 4));
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int p = 0; p < 12; p++) begin
      clear_logs();
      len = $urandom_range(0, 6);
      for (int k = 0; k < len; k++) add_tok(2'($urandom_range(0, 2)), 8'($urandom));
      add_tok(3, 8'($urandom));
      ref_run();
      send_prog(2);
      wait_done(600);
      checks++;
      if (pq.size() != exp_q.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d, required %0d", p, pq.size(), exp_q.size());
      end else begin
        foreach (pq[i]) begin
          checks++;
          if (pq[i].op !== exp_q[i].op || (exp_q[i].op == 2'd0 && pq[i].d !== exp_q[i].d)) begin
            errors++; $display("FAIL rand%0d_pulse[%0d]: got %0d/%h, required %0d/%h",
                               p, i, pq[i].op, pq[i].d, exp_q[i].op, exp_q[i].d);
          end
        end
      end
      if (dq.size() > 0) begin
        checks++;
        if (dq[0].r !== exp_res || dq[0].o !== exp_ovf || dq[0].e !== exp_err) begin
          errors++; $display("FAIL rand%0d_final: got %h/%b/%h, required %h/%b/%h",
                             p, dq[0].r, dq[0].o, dq[0].e, exp_res, exp_ovf, exp_err);
        end
      end
    end
    wait_idle(400);
  endtask

  task automatic test_reset_mid();
    int n;
    clear_logs();
    add_tok(0, 8'h01); add_tok(0, 8'h02); add_tok(1, 0); add_tok(3, 0);
    send_prog(0);
    n = 0;
    while (pq.size() < 2 && n < 100) begin @(negedge clock); n++; end
    checks++;
    if (pq.size() < 2) begin
      errors++; $display("FAIL rst_mid_setup: got %0d pulses, required 2", pq.size());
    end else begin
      while (cyc < pq[1].c + 1) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checks += 3;
      if ({calc_enter, calc_add, calc_multiply, calc_clear, calc_data, done} !== 13'h0) begin
        errors++; $display("FAIL rst_mid_outputs: got %h, required 0",
                           {calc_enter, calc_add, calc_multiply, calc_clear, calc_data, done});
      end
      if ({final_result, final_overflow, final_error} !== 21'h0) begin
        errors++; $display("FAIL rst_mid_final: got %h, required 0", {final_result, final_overflow, final_error});
      end
      if (busy !== 1'b0 || host.cmd_ready !== 1'b1) begin
        errors++; $display("FAIL rst_mid_fifo: got busy %b ready %b, required 0 1", busy, host.cmd_ready);
      end
      reset = 1'b0;
      repeat (20) @(negedge clock);
      checks++;
      if (pq.size() != 2 || dq.size() != 0) begin
        errors++; $display("FAIL rst_mid_quiet: got %0d pulses %0d done, required 2 pulses 0 done",
                           pq.size(), dq.size());
      end
    end
    clear_logs();
    add_tok(0, 8'h01); add_tok(0, 8'h01); add_tok(1, 0); add_tok(3, 0);
    send_prog(0);
    wait_done(400);
    wait_idle(400);
    if (dq.size() > 0) begin
      checks++;
      if (dq[0].r !== 16'h0002) begin
        errors++; $display("FAIL rst_mid_rerun: got %h, required 0002", dq[0].r);
      end
    end
  endtask

  initial begin
    host.cmd_valid = 1'b0;
    host.cmd_op    = 2'd0;
    host.cmd_data  = 8'h00;
    saw_full       = 1'b0;
    test_reset();
    test_basic();
    test_empty_end();
    test_overflow();
    test_error_flush();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
